// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package div_sched_pkg;

    // Scheduler states: arbitrate, pulse the engine, wait for it, return the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Quotient reported for a divide-by-zero; sliced down to XLEN where used.
    localparam int MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] DIV0_QUOTIENT = '1;

    // Response qualifiers carried alongside quotient/remainder.
    typedef struct packed {
        logic err;
        logic div0;
    } rsp_flags_t;

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the pointer wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_gnt_idx
);

    int            w_k;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // Scan NREQ positions starting at the pointer, wrapping past NREQ-1 to 0.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_k       = 0;
        w_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k   = (int'(i_ptr) + i) % NREQ;
            w_idx = IW'(w_k);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one serial divider between NREQ requesters: round-robin accept,
// issue to the engine, wait with timeout, return result over valid/ready.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*XLEN-1:0]      req_dividend_i,
    input  logic [NREQ*XLEN-1:0]      req_divisor_i,
    output logic [NREQ-1:0]           rsp_valid_o,
    input  logic [NREQ-1:0]           rsp_ready_i,
    output logic [XLEN-1:0]           rsp_quotient_o,
    output logic [XLEN-1:0]           rsp_remainder_o,
    output logic                      rsp_err_o,
    output logic                      rsp_div0_o,
    output logic                      div_start_o,
    output logic [XLEN-1:0]           div_dividend_o,
    output logic [XLEN-1:0]           div_divisor_o,
    input  logic                      div_done_i,
    input  logic [XLEN-1:0]           div_quotient_i,
    input  logic [XLEN-1:0]           div_remainder_i,
    output logic                      busy_o,
    output logic [$clog2(NREQ)-1:0]   owner_o
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     w_gnt_idx;
    logic [NREQ-1:0]   w_gnt;
    logic [XLEN-1:0]   w_req_dvd [NREQ];
    logic [XLEN-1:0]   w_req_dvs [NREQ];
    logic [XLEN-1:0]   w_sel_dvd;
    logic [XLEN-1:0]   w_sel_dvs;
    logic              w_accept;
    logic              w_sel_div0;
    logic              w_rsp_hs;
    logic              w_timeout;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [XLEN-1:0]   r_dividend;
    logic [XLEN-1:0]   r_divisor;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_rem;
    rsp_flags_t        r_flags;

    // Unpack the per-requester operand buses so the winner can be picked by index.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_req_dvd[g] = req_dividend_i[g*XLEN +: XLEN];
        assign w_req_dvs[g] = req_divisor_i[g*XLEN +: XLEN];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req     (req_valid_i),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_sel_dvd  = w_req_dvd[w_gnt_idx];
    assign w_sel_dvs  = w_req_dvs[w_gnt_idx];
    assign w_sel_div0 = (w_sel_dvs == '0);
    // Ready is never raised during reset, so no handshake can slip through it.
    assign w_accept   = (r_state == IDLE) && !reset_i && (|(req_valid_i & w_gnt));
    // Only the owner's ready bit closes the response.
    assign w_rsp_hs   = (r_state == RESP) && rsp_ready_i[r_owner];
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT - 1));

    assign rsp_quotient_o  = r_quot;
    assign rsp_remainder_o = r_rem;
    assign rsp_err_o       = r_flags.err;
    assign rsp_div0_o      = r_flags.div0;
    assign div_dividend_o  = r_dividend;
    assign div_divisor_o   = r_divisor;
    assign owner_o         = r_owner;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; done takes priority over the timeout in WAIT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_sel_div0 ? RESP : ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (div_done_i || w_timeout) w_next_state = RESP;
            RESP:    if (w_rsp_hs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Per-state control outputs.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        div_start_o = 1'b0;
        busy_o      = (r_state != IDLE);
        case (r_state)
            IDLE:    if (!reset_i) req_ready_o = w_gnt;
            ISSUE:   div_start_o = 1'b1;
            RESP:    rsp_valid_o[r_owner] = 1'b1;
            default: ;
        endcase
    end

    // Operand, result, owner, pointer and timeout-counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_flags    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dividend <= w_sel_dvd;
                        r_divisor  <= w_sel_dvs;
                        r_owner    <= w_gnt_idx;
                        if (w_sel_div0) begin
                            r_quot  <= DIV0_QUOTIENT[XLEN-1:0];
                            r_rem   <= w_sel_dvd;
                            r_flags <= '{err: 1'b0, div0: 1'b1};
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (div_done_i) begin
                        r_quot  <= div_quotient_i;
                        r_rem   <= div_remainder_i;
                        r_flags <= '0;
                    end else if (w_timeout) begin
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_flags <= '{err: 1'b1, div0: 1'b0};
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_ptr   <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                        r_flags <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Testbench for div_sched with a fixed-latency mock divider engine.
module tb_div_sched;

    localparam int NREQ    = 2;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;
    localparam int ENG_L   = 33;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid_i = '0;
    logic [NREQ-1:0]      req_ready_o;
    logic [XLEN-1:0]      a_op [NREQ];
    logic [XLEN-1:0]      b_op [NREQ];
    logic [NREQ*XLEN-1:0] req_dividend_i;
    logic [NREQ*XLEN-1:0] req_divisor_i;
    logic [NREQ-1:0]      rsp_valid_o;
    logic [NREQ-1:0]      rsp_ready_i = '0;
    logic [XLEN-1:0]      rsp_quotient_o;
    logic [XLEN-1:0]      rsp_remainder_o;
    logic                 rsp_err_o;
    logic                 rsp_div0_o;
    logic                 div_start_o;
    logic [XLEN-1:0]      div_dividend_o;
    logic [XLEN-1:0]      div_divisor_o;
    logic                 div_done_i;
    logic [XLEN-1:0]      div_quotient_i;
    logic [XLEN-1:0]      div_remainder_i;
    logic                 busy_o;
    logic [0:0]           owner_o;

    logic                 stray = 1'b0;
    logic                 eng_hang = 1'b0;
    logic                 eng_busy, eng_done;
    int                   eng_cnt;
    logic [XLEN-1:0]      eng_q, eng_r;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    assign req_dividend_i  = {a_op[1], a_op[0]};
    assign req_divisor_i   = {b_op[1], b_op[0]};
    assign div_done_i      = eng_done | stray;
    assign div_quotient_i  = stray ? 32'hDEADBEEF : eng_q;
    assign div_remainder_i = stray ? 32'hBADC0DE0 : eng_r;

    always #5 clk = ~clk;

    div_sched #(.NREQ(NREQ), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_quotient_o(rsp_quotient_o), .rsp_remainder_o(rsp_remainder_o),
        .rsp_err_o(rsp_err_o), .rsp_div0_o(rsp_div0_o),
        .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_done_i(div_done_i), .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    // Mock engine: done pulses ENG_L cycles after the start pulse; shares reset.
    always @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0; eng_done <= 1'b0; eng_cnt <= 0; eng_q <= '0; eng_r <= '0;
        end else begin
            eng_done <= 1'b0;
            if (div_start_o && !eng_busy && !eng_hang) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 1;
                eng_q    <= (div_divisor_o == 0) ? '1 : div_dividend_o / div_divisor_o;
                eng_r    <= (div_divisor_o == 0) ? div_dividend_o : div_dividend_o % div_divisor_o;
            end else if (eng_busy) begin
                if (eng_cnt == ENG_L - 1) begin
                    eng_done <= 1'b1;
                    eng_busy <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt + 1;
                end
            end
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid_i = '0; rsp_ready_i = '0; stray = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Presents mask each cycle until a handshake is pending; g = granted index.
    task automatic wait_accept(input logic [NREQ-1:0] mask, output int g, output int tries);
        g = -1; tries = 0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            req_valid_i = mask;
            #1;
            if ((req_ready_o & req_valid_i) != 0) begin
                g = req_ready_o[1] ? 1 : 0;
                tries = t;
                break;
            end
        end
    endtask

    // Counts cycles after the accept cycle until rsp_valid_o rises.
    task automatic wait_rsp(input bit clr, output int cyc, output int starts, output int scyc,
                            output logic [XLEN-1:0] sdvd, output logic [XLEN-1:0] sdvs);
        cyc = -1; starts = 0; scyc = -1; sdvd = '0; sdvs = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (clr) req_valid_i = '0;
            #1;
            if (div_start_o) begin
                starts++;
                if (scyc < 0) begin scyc = c; sdvd = div_dividend_o; sdvs = div_divisor_o; end
            end
            if (rsp_valid_o != 0) begin cyc = c; break; end
        end
    endtask

    task automatic ack(input int k);
        @(negedge clk);
        rsp_ready_i = '0;
        rsp_ready_i[k] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = '0;
        m_ptr = (k + 1) % NREQ;
    endtask

    task automatic test_reset();
        req_valid_i = 2'b01; a_op[0] = 32'd5; b_op[0] = 32'd1;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready_o); end
        n_checks++; if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
        n_checks++; if ({rsp_quotient_o, rsp_remainder_o} !== 64'd0) begin n_fail++; $display("FAIL reset_results: got %h %h want 0 0", rsp_quotient_o, rsp_remainder_o); end
        n_checks++; if ({rsp_err_o, rsp_div0_o, div_start_o, owner_o} !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {rsp_err_o, rsp_div0_o, div_start_o, owner_o}); end
        n_checks++; if ({div_dividend_o, div_divisor_o} !== 64'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h want 0 0", div_dividend_o, div_divisor_o); end
        req_valid_i = '0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int g, tries, cyc, starts, scyc;
        logic [XLEN-1:0] sdvd, sdvs;
        do_reset();
        a_op[0] = 32'd100; b_op[0] = 32'd7;
        wait_accept(2'b01, g, tries);
        n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL basic_ready: got %b want 01", req_ready_o); end
        wait_rsp(1'b1, cyc, starts, scyc, sdvd, sdvs);
        n_checks++; if (scyc !== 1 || starts !== 1) begin n_fail++; $display("FAIL basic_start: got cycle %0d count %0d want cycle 1 count 1", scyc, starts); end
        n_checks++; if (sdvd !== 32'd100 || sdvs !== 32'd7) begin n_fail++; $display("FAIL basic_operands: got %0d/%0d want 100/7", sdvd, sdvs); end
        n_checks++; if (cyc !== 2 + ENG_L) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, 2 + ENG_L); end
        n_checks++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL basic_rsp_valid: got %b want 01", rsp_valid_o); end
        n_checks++; if (rsp_quotient_o !== 32'd14 || rsp_remainder_o !== 32'd2) begin n_fail++; $display("FAIL basic_result: got %0d r%0d want 14 r2", rsp_quotient_o, rsp_remainder_o); end
        n_checks++; if ({rsp_err_o, rsp_div0_o} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {rsp_err_o, rsp_div0_o}); end
        ack(0);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after_ack: got busy %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int g, tries, cyc, starts, scyc, exp_g;
        logic [XLEN-1:0] sdvd, sdvs, eq, er;
        do_reset();
        a_op[0] = 32'hFFFFFFFF; b_op[0] = 32'd16;
        a_op[1] = 32'd50;       b_op[1] = 32'd5;
        for (int t = 0; t < 4; t++) begin
            exp_g = rr_pick(2'b11, m_ptr);
            wait_accept(2'b11, g, tries);
            n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL b2b_grant%0d: got %0d want %0d", t, g, exp_g); end
            n_checks++; if (t > 0 && tries !== 1) begin n_fail++; $display("FAIL b2b_accept_gap%0d: got %0d cycles want 1", t, tries); end
            if (g < 0) return;
            wait_rsp(1'b0, cyc, starts, scyc, sdvd, sdvs);
            eq = a_op[exp_g] / b_op[exp_g];
            er = a_op[exp_g] % b_op[exp_g];
            n_checks++; if (rsp_quotient_o !== eq || rsp_remainder_o !== er) begin n_fail++; $display("FAIL b2b_result%0d: got %h r%0d want %h r%0d", t, rsp_quotient_o, rsp_remainder_o, eq, er); end
            n_checks++; if (owner_o !== 1'(exp_g)) begin n_fail++; $display("FAIL b2b_owner%0d: got %0d want %0d", t, owner_o, exp_g); end
            ack(g);
        end
        req_valid_i = '0;
    endtask

    task automatic test_div0();
        int g, tries, cyc, starts, scyc;
        logic [XLEN-1:0] sdvd, sdvs;
        do_reset();
        a_op[1] = 32'h1234; b_op[1] = 32'd0;
        wait_accept(2'b10, g, tries);
        wait_rsp(1'b1, cyc, starts, scyc, sdvd, sdvs);
        n_checks++; if (cyc !== 1 || starts !== 0) begin n_fail++; $display("FAIL div0_latency: got cycle %0d starts %0d want 1 and 0", cyc, starts); end
        n_checks++; if (rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL div0_rsp_valid: got %b want 10", rsp_valid_o); end
        n_checks++; if (rsp_quotient_o !== 32'hFFFFFFFF || rsp_remainder_o !== 32'h1234) begin n_fail++; $display("FAIL div0_result: got %h r%h want ffffffff r1234", rsp_quotient_o, rsp_remainder_o); end
        n_checks++; if ({rsp_err_o, rsp_div0_o} !== 2'b01) begin n_fail++; $display("FAIL div0_flags: got %b want 01", {rsp_err_o, rsp_div0_o}); end
        ack(1);
        n_checks++; if (rsp_div0_o !== 1'b0) begin n_fail++; $display("FAIL div0_flag_clear: got %b want 0", rsp_div0_o); end
    endtask

    task automatic test_timeout();
        int g, tries, cyc, starts, scyc;
        logic [XLEN-1:0] sdvd, sdvs;
        do_reset();
        eng_hang = 1'b1;
        a_op[0] = 32'd77; b_op[0] = 32'd3;
        wait_accept(2'b01, g, tries);
        wait_rsp(1'b1, cyc, starts, scyc, sdvd, sdvs);
        n_checks++; if (cyc !== 1 + TIMEOUT) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", cyc, 1 + TIMEOUT); end
        n_checks++; if ({rsp_err_o, rsp_div0_o} !== 2'b10) begin n_fail++; $display("FAIL timeout_flags: got %b want 10", {rsp_err_o, rsp_div0_o}); end
        n_checks++; if (rsp_quotient_o !== 32'd0 || rsp_remainder_o !== 32'd0) begin n_fail++; $display("FAIL timeout_result: got %h r%h want 0 r0", rsp_quotient_o, rsp_remainder_o); end
        ack(0);
        eng_hang = 1'b0;
    endtask

    task automatic test_hold_stray();
        int g, tries, cyc, starts, scyc;
        logic [XLEN-1:0] sdvd, sdvs;
        do_reset();
        a_op[0] = 32'd1000; b_op[0] = 32'd9;
        a_op[1] = 32'd20;   b_op[1] = 32'd4;
        wait_accept(2'b01, g, tries);
        wait_rsp(1'b1, cyc, starts, scyc, sdvd, sdvs);
        rsp_ready_i = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid_i = 2'b10;
            stray = (i == 3);
            #1;
            n_checks++; if (rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL hold_valid%0d: got %b want 01", i, rsp_valid_o); end
            n_checks++; if (rsp_quotient_o !== 32'd111 || rsp_remainder_o !== 32'd1) begin n_fail++; $display("FAIL hold_result%0d: got %0d r%0d want 111 r1", i, rsp_quotient_o, rsp_remainder_o); end
            n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL hold_no_ready%0d: got %b want 00", i, req_ready_o); end
        end
        @(negedge clk);
        stray = 1'b0;
        rsp_ready_i = 2'b01;
        #1;
        n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL hold_ready_in_ack: got %b want 00", req_ready_o); end
        @(posedge clk);
        #1;
        rsp_ready_i = '0;
        m_ptr = 1;
        @(negedge clk);
        #1;
        n_checks++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL hold_ready_after_ack: got %b want 10", req_ready_o); end
        n_checks++; if (rsp_err_o !== 1'b0 || rsp_div0_o !== 1'b0) begin n_fail++; $display("FAIL hold_flags: got %b want 00", {rsp_err_o, rsp_div0_o}); end
        req_valid_i = '0;
    endtask

    task automatic test_reset_in_wait();
        int g, tries, cyc, starts, scyc;
        logic [XLEN-1:0] sdvd, sdvs;
        do_reset();
        a_op[0] = 32'd500; b_op[0] = 32'd7;
        wait_accept(2'b01, g, tries);
        repeat (6) @(negedge clk);
        req_valid_i = '0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy: got %b want 0", busy_o); end
        n_checks++; if ({rsp_valid_o, req_ready_o, div_start_o, rsp_err_o, rsp_div0_o, owner_o} !== 8'd0) begin n_fail++; $display("FAIL rstwait_ctrl: got %b want 0", {rsp_valid_o, req_ready_o, div_start_o, rsp_err_o, rsp_div0_o, owner_o}); end
        n_checks++; if ({rsp_quotient_o, rsp_remainder_o, div_dividend_o, div_divisor_o} !== 128'd0) begin n_fail++; $display("FAIL rstwait_data: got %h %h %h %h want 0", rsp_quotient_o, rsp_remainder_o, div_dividend_o, div_divisor_o); end
        rst = 1'b0;
        m_ptr = 0;
        a_op[0] = 32'd9; b_op[0] = 32'd3;
        wait_accept(2'b01, g, tries);
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL rstwait_grant: got %0d want 0", g); end
        wait_rsp(1'b1, cyc, starts, scyc, sdvd, sdvs);
        n_checks++; if (cyc !== 2 + ENG_L) begin n_fail++; $display("FAIL rstwait_latency: got %0d want %0d", cyc, 2 + ENG_L); end
        n_checks++; if (rsp_quotient_o !== 32'd3 || rsp_remainder_o !== 32'd0) begin n_fail++; $display("FAIL rstwait_result: got %0d r%0d want 3 r0", rsp_quotient_o, rsp_remainder_o); end
        ack(0);
    endtask

    task automatic test_random();
        int g, tries, cyc, starts, scyc, exp_g, exp_cyc, sel;
        logic [NREQ-1:0] mask;
        logic [XLEN-1:0] sdvd, sdvs, eq, er;
        logic [NREQ-1:0] exp_v;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < NREQ; k++) begin
                sel = $urandom_range(0, 7);
                a_op[k] = (sel == 7) ? 32'($urandom_range(0, 50)) : 32'($urandom);
                b_op[k] = (sel < 2) ? 32'd0 : (sel < 5) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            end
            mask  = NREQ'($urandom_range(1, 3));
            exp_g = rr_pick(mask, m_ptr);
            wait_accept(mask, g, tries);
            n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL rand_grant%0d: got %0d want %0d", t, g, exp_g); end
            if (g < 0) return;
            eq      = (b_op[g] == 0) ? 32'hFFFFFFFF : a_op[g] / b_op[g];
            er      = (b_op[g] == 0) ? a_op[g] : a_op[g] % b_op[g];
            exp_cyc = (b_op[g] == 0) ? 1 : 2 + ENG_L;
            exp_v   = '0;
            exp_v[g] = 1'b1;
            wait_rsp(1'b1, cyc, starts, scyc, sdvd, sdvs);
            n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL rand_latency%0d: got %0d want %0d", t, cyc, exp_cyc); end
            n_checks++; if (rsp_valid_o !== exp_v) begin n_fail++; $display("FAIL rand_rsp_valid%0d: got %b want %b", t, rsp_valid_o, exp_v); end
            n_checks++; if (rsp_quotient_o !== eq || rsp_remainder_o !== er) begin n_fail++; $display("FAIL rand_result%0d: got %h r%h want %h r%h", t, rsp_quotient_o, rsp_remainder_o, eq, er); end
            n_checks++; if ({rsp_err_o, rsp_div0_o} !== {1'b0, (b_op[g] == 0)}) begin n_fail++; $display("FAIL rand_flags%0d: got %b want %b", t, {rsp_err_o, rsp_div0_o}, {1'b0, (b_op[g] == 0)}); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack(g);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NREQ; k++) begin a_op[k] = '0; b_op[k] = '0; end
        test_reset();
        test_basic();
        test_back_to_back();
        test_div0();
        test_timeout();
        test_hold_stray();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one serial_divider engine between NREQ requesters, e.g. the Wishbone path and the LA debug path.
- Accepts one divide request at a time, issues it to the engine and waits for completion.
- Returns quotient and remainder to the owning requester over a valid/ready response channel.
- Handles divide-by-zero locally and guards against a hung engine with a timeout.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- XLEN, 32, operand and result width.
- TIMEOUT, 64, maximum cycles to wait for div_done_i before aborting; must be greater than the engine latency.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  reset, synchronous, active-high
- req_valid_i  input  NREQ  per-requester request valid
- req_ready_o  output  NREQ  per-requester request accept; at most one bit set
- req_dividend_i  input  NREQ*XLEN  packed dividends; requester k occupies bits [k*XLEN +: XLEN]
- req_divisor_i  input  NREQ*XLEN  packed divisors, same packing
- rsp_valid_o  output  NREQ  per-requester response valid; at most one bit set
- rsp_ready_i  input  NREQ  per-requester response accept
- rsp_quotient_o  output  XLEN  quotient, shared by all requesters
- rsp_remainder_o  output  XLEN  remainder, shared by all requesters
- rsp_err_o  output  1  response is a timeout abort
- rsp_div0_o  output  1  response is a divide-by-zero result
- div_start_o  output  1  one-cycle start pulse to the engine
- div_dividend_o  output  XLEN  engine dividend operand
- div_divisor_o  output  XLEN  engine divisor operand
- div_done_i  input  1  engine completion pulse
- div_quotient_i  input  XLEN  engine quotient, valid with div_done_i
- div_remainder_i  input  XLEN  engine remainder, valid with div_done_i
- busy_o  output  1  high in any state other than IDLE
- owner_o  output  $clog2(NREQ)  index of the current owner

Behaviour:
- Reset, sampled on the clock edge:
  - state goes to IDLE; round-robin pointer and owner go to 0.
  - all outputs go to 0, including operand and result registers.
- Reset mid-operation aborts the transaction without producing a response. The engine shares reset_i.
- Arbitration, state IDLE:
  - The winner is the first k with req_valid_i[k] set, searching from the pointer upward and wrapping at NREQ-1 -> 0.
  - req_ready_o[winner] is driven combinationally in IDLE only.
  - Handshake is req_valid_i & req_ready_o. On handshake: latch the operands, owner = winner, then:
    - divisor == 0 -> state RESP with quotient = all ones, remainder = dividend, rsp_div0_o = 1; the engine is not used.
    - otherwise -> state ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: div_start_o = 1 for exactly one cycle. div_dividend_o and div_divisor_o hold the latched operands from ISSUE through WAIT. Clear the timeout counter and go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - div_done_i = 1 -> latch div_quotient_i and div_remainder_i, go to RESP. Done wins if it arrives on the same cycle the counter reaches TIMEOUT-1.
  - Counter reaches TIMEOUT-1 without done -> go to RESP with quotient = 0, remainder = 0, rsp_err_o = 1.
  - div_done_i is ignored in any state other than WAIT.
- RESP:
  - rsp_valid_o[owner] = 1; result outputs and flags are held stable until rsp_ready_i[owner].
  - On that handshake: pointer = (owner+1) mod NREQ, clear the flags, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
  - rsp_ready_i bits of non-owners are ignored.
- Latency, with engine latency L measured from the start pulse to done:
  - accept at cycle 0, div_start_o at cycle 1, done at cycle 1+L, rsp_valid at cycle 2+L.
  - divide-by-zero: rsp_valid at cycle 1.
- Requests are unsigned. Width rules follow XLEN throughout; there is no sign handling.
- A requester must hold its valid and operands stable until accepted. It may deassert valid before acceptance without side effects.

Decomposition:
- div_sched_pkg holds:
  - the state enum: IDLE, ISSUE, WAIT, RESP
  - the DIV0_QUOTIENT constant (all ones)
  - the err/div0 flag struct
- One sub-module, rr_arbiter: parameter NREQ; inputs req and pointer; outputs a one-hot grant and the grant index; purely combinational.
- The FSM, timeout counter and data registers stay in div_sched.

Test Plan:
- Use a mock engine with fixed latency 33.
- Requester 0 sends 100/7 -> div_start_o one cycle after accept; rsp_valid_o = 01 at cycle 35 with quotient 14, remainder 2, both flags 0.
- Both requesters valid continuously, with 0xFFFFFFFF/16 and 50/5 -> grants alternate 0,1,0,1; responses 0x0FFFFFFF r15 and 10 r0.
- Requester 1 sends 0x1234/0 -> no div_start_o; rsp_valid_o = 10 at cycle 1; quotient 0xFFFFFFFF, remainder 0x1234, rsp_div0_o = 1.
- Mock engine never asserts done -> rsp_err_o = 1, quotient 0, remainder 0 at cycle 1+TIMEOUT, i.e. cycle 65 when TIMEOUT = 64.
- Hold rsp_ready_i low for 10 cycles -> results stable and no new req_ready_o; a stray div_done_i pulse in RESP changes nothing.
- Assert reset_i in WAIT -> next cycle busy_o = 0 and all outputs 0; a following 9/3 request completes normally with quotient 3, remainder 0.
